// File: rtl/pc_ras.sv
// Next-PC generator with circular return-address stack; cpc is registered (1 cycle), npc combinational.
// No backpressure: pcEn stalls the PC and RAS, redirect overrides everything except RST.
module pc_ras #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   PC_INIT   = '0,
    parameter int                 IMM_W     = 26,
    parameter int                 RAS_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             pcEn,
    input  logic [2:0]       pcSel,
    input  logic             link,
    input  logic [WIDTH-1:0] rdat,
    input  logic [IMM_W-1:0] immJ26,
    input  logic [WIDTH-1:0] ext32,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] cpc,
    output logic [WIDTH-1:0] npc,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_unf,
    output logic             misalign
);
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [2:0] SEL_JR   = 3'd1;
    localparam logic [2:0] SEL_JUMP = 3'd2;
    localparam logic [2:0] SEL_BR   = 3'd3;
    localparam logic [2:0] SEL_RET  = 3'd4;

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_inc;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] jump_tgt;
    logic [WIDTH-1:0] raw_tgt;
    logic [WIDTH-1:0] tgt;
    logic             chk_align;
    logic             tgt_mis;
    logic             have_top;
    logic             is_ret;
    logic             adv;

    assign npc       = cpc + WIDTH'(4);
    assign ptr_inc   = ptr + PW'(1);
    assign have_top  = (count != '0);
    assign ras_empty = (count == '0);
    assign ras_full  = (count == CW'(RAS_DEPTH));
    assign is_ret    = (pcSel == SEL_RET);
    assign adv       = pcEn && !redirect;

    always_comb begin
        jump_tgt              = npc;
        jump_tgt[IMM_W+1:0]   = {immJ26, 2'b00};
        raw_tgt               = npc;
        chk_align             = 1'b0;
        case (pcSel)
            SEL_JR:   begin raw_tgt = rdat; chk_align = 1'b1; end
            SEL_JUMP: raw_tgt = jump_tgt;
            SEL_BR:   raw_tgt = npc + (ext32 << 2);
            SEL_RET:  begin raw_tgt = have_top ? ras_mem[ptr] : rdat; chk_align = 1'b1; end
            default:  raw_tgt = npc;
        endcase
        tgt_mis = chk_align && (raw_tgt[1:0] != 2'b00);
        tgt     = chk_align ? (raw_tgt & ~WIDTH'(3)) : raw_tgt;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cpc      <= PC_INIT;
            ptr      <= '0;
            count    <= '0;
            ras_ovf  <= 1'b0;
            ras_unf  <= 1'b0;
            misalign <= 1'b0;
        end else if (redirect) begin
            cpc <= redirect_pc & ~WIDTH'(3);
        end else if (pcEn) begin
            cpc <= tgt;
            if (tgt_mis)
                misalign <= 1'b1;
            if (is_ret) begin
                // RET+link swaps the top in place; an empty stack gains one entry.
                if (!have_top) begin
                    ras_unf <= 1'b1;
                    if (link)
                        count <= CW'(1);
                end else if (!link) begin
                    ptr   <= ptr - PW'(1);
                    count <= count - CW'(1);
                end
            end else if (link) begin
                ptr <= ptr_inc;
                if (ras_full)
                    ras_ovf <= 1'b1;
                else
                    count <= count + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && adv && link) begin
            if (is_ret)
                ras_mem[ptr] <= npc;
            else
                ras_mem[ptr_inc] <= npc;
        end
    end
endmodule

// File: tb/tb_pc_ras.sv
// Directed test-plan steps followed by random cycles, checked against a queue-based model.
module tb_pc_ras;
    logic        CLK = 1'b0;
    logic        RST;
    logic        pcEn;
    logic [2:0]  pcSel;
    logic        link;
    logic [31:0] rdat;
    logic [25:0] immJ26;
    logic [31:0] ext32;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] cpc;
    logic [31:0] npc;
    logic        ras_empty, ras_full, ras_ovf, ras_unf, misalign;

    always #5 CLK = ~CLK;

    pc_ras #(.WIDTH(32), .PC_INIT(32'h100), .IMM_W(26), .RAS_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .pcEn(pcEn), .pcSel(pcSel), .link(link),
        .rdat(rdat), .immJ26(immJ26), .ext32(ext32), .redirect(redirect),
        .redirect_pc(redirect_pc), .cpc(cpc), .npc(npc), .ras_empty(ras_empty),
        .ras_full(ras_full), .ras_ovf(ras_ovf), .ras_unf(ras_unf), .misalign(misalign)
    );

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model: return stack as a queue, newest at the back.
    logic [31:0] m_cpc;
    logic [31:0] m_ras[$];
    bit          m_ovf, m_unf, m_mis;
    logic [31:0] pushed [5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [31:0] n, t;
        if (RST) begin
            m_cpc = 32'h100;
            m_ras.delete();
            m_ovf = 0; m_unf = 0; m_mis = 0;
        end else if (redirect) begin
            m_cpc = {redirect_pc[31:2], 2'b00};
        end else if (pcEn) begin
            n = m_cpc + 32'd4;
            case (pcSel)
                3'd1:    t = rdat;
                3'd2:    t = {n[31:28], immJ26, 2'b00};
                3'd3:    t = n + (ext32 * 32'd4);
                3'd4:    t = (m_ras.size() > 0) ? m_ras[$] : rdat;
                default: t = n;
            endcase
            if ((pcSel == 3'd1 || pcSel == 3'd4) && t[1:0] != 2'b00) begin
                m_mis = 1;
                t = {t[31:2], 2'b00};
            end
            if (pcSel == 3'd4) begin
                if (m_ras.size() > 0) begin
                    if (link) m_ras[m_ras.size()-1] = n;
                    else void'(m_ras.pop_back());
                end else begin
                    m_unf = 1;
                    if (link) m_ras.push_back(n);
                end
            end else if (link) begin
                m_ras.push_back(n);
                if (m_ras.size() > 4) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1;
                end
            end
            m_cpc = t;
        end
    endtask

    task automatic cyc(input string tag);
        model_step();
        @(posedge CLK);
        #1;
        chk({tag, ".cpc"}, cpc, m_cpc);
        chk({tag, ".npc"}, npc, m_cpc + 32'd4);
        chk({tag, ".empty"}, 32'(ras_empty), 32'(m_ras.size() == 0));
        chk({tag, ".full"}, 32'(ras_full), 32'(m_ras.size() == 4));
        chk({tag, ".ovf"}, 32'(ras_ovf), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(ras_unf), 32'(m_unf));
        chk({tag, ".mis"}, 32'(misalign), 32'(m_mis));
    endtask

    task automatic idle();
        RST = 0; pcEn = 0; pcSel = 3'd0; link = 0; redirect = 0;
    endtask

    task automatic go(input logic [31:0] pc);
        idle(); redirect = 1; redirect_pc = pc;
        cyc("redir");
        redirect = 0;
    endtask

    initial begin
        idle();
        rdat = 0; immJ26 = 0; ext32 = 0; redirect_pc = 0;
        m_cpc = 0; m_ovf = 0; m_unf = 0; m_mis = 0;

        RST = 1;
        cyc("reset");
        chk("reset_pc", cpc, 32'h100);
        RST = 0;

        pcEn = 1;
        cyc("npc1"); chk("seq1", cpc, 32'h104);
        cyc("npc2"); chk("seq2", cpc, 32'h108);
        cyc("npc3"); chk("seq3", cpc, 32'h10C);
        chk("seq_empty", 32'(ras_empty), 32'd1);

        go(32'h400);
        pcEn = 1; pcSel = 3'd3; ext32 = 32'hFFFF_FFFE;
        cyc("br_back"); chk("br_back_pc", cpc, 32'h3FC);

        go(32'hFFFF_FFFC);
        pcEn = 1; pcSel = 3'd0;
        cyc("wrap"); chk("wrap_pc", cpc, 32'h0);

        go(32'h1000_0010);
        pcEn = 1; pcSel = 3'd2; immJ26 = 26'h40; link = 1;
        cyc("jal"); chk("jal_pc", cpc, 32'h1000_0100);
        link = 0; pcSel = 3'd4;
        cyc("ret"); chk("ret_pc", cpc, 32'h1000_0014);
        chk("ret_empty", 32'(ras_empty), 32'd1);

        pcSel = 3'd0; link = 1;
        for (int i = 0; i < 5; i++) begin
            pushed[i] = cpc + 32'd4;
            cyc("push");
        end
        chk("ovf_full", 32'(ras_full), 32'd1);
        chk("ovf_set", 32'(ras_ovf), 32'd1);
        link = 0; pcSel = 3'd4; rdat = 32'h5550;
        for (int i = 4; i >= 1; i--) begin
            cyc("pop");
            chk("pop_order", cpc, pushed[i]);
        end
        rdat = 32'h2000;
        cyc("underflow"); chk("unf_pc", cpc, 32'h2000);
        chk("unf_set", 32'(ras_unf), 32'd1);

        pcSel = 3'd0; link = 1;
        cyc("pushA"); cyc("pushB");
        redirect = 1; redirect_pc = 32'h8000_0180; pcSel = 3'd4;
        cyc("redir_pri"); chk("redir_pc", cpc, 32'h8000_0180);
        redirect = 0; pcEn = 0; link = 0;
        cyc("hold1"); cyc("hold2"); chk("hold_pc", cpc, 32'h8000_0180);
        pcEn = 1; pcSel = 3'd4;
        cyc("ret_after_redir");

        pcSel = 3'd1; rdat = 32'h1003;
        cyc("jr_mis"); chk("jr_mis_pc", cpc, 32'h1000);
        chk("mis_set", 32'(misalign), 32'd1);

        pcSel = 3'd0; link = 1;
        cyc("p1"); cyc("p2"); cyc("p3");
        idle(); RST = 1; pcEn = 1; link = 1; redirect = 1;
        cyc("mid_rst");
        chk("mid_rst_pc", cpc, 32'h100);
        chk("mid_rst_empty", 32'(ras_empty), 32'd1);
        chk("mid_rst_sticky", {29'b0, ras_ovf, ras_unf, misalign}, 32'd0);

        for (int i = 0; i < 400; i++) begin
            RST         = ($urandom_range(0, 59) == 0);
            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = $urandom;
            pcEn        = ($urandom_range(0, 3) != 0);
            pcSel       = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) pcSel = 3'd4;
            link        = ($urandom_range(0, 2) == 0);
            rdat        = $urandom;
            if ($urandom_range(0, 1) == 0) rdat[1:0] = 2'b00;
            immJ26      = 26'($urandom);
            ext32       = ($urandom_range(0, 1) == 0) ? 32'($signed(8'($urandom))) : $urandom;
            cyc("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
